// File: rtl/tl_pkt_pkg.sv
// Shared definitions for the 16-byte TileLink packet format used between the
// UART bridge, its requesters and the transaction scheduler.
package tl_pkt_pkg;

    localparam int PKT_W = 128;

    // Byte offsets inside a packet (byte 0 lives in bits [7:0])
    localparam int OFF_CHAN  = 0;
    localparam int OFF_OPC   = 1;
    localparam int OFF_SIZE  = 2;
    localparam int OFF_UNION = 3;
    localparam int OFF_ADDR  = 4;
    localparam int OFF_DATA  = 8;

    // Channel identifiers
    localparam logic [2:0] CH_A = 3'd0;
    localparam logic [2:0] CH_D = 3'd3;

    // Opcodes
    localparam logic [3:0] OPC_GET             = 4'd4;
    localparam logic [3:0] OPC_PUT_FULL        = 4'd0;
    localparam logic [3:0] OPC_ACCESS_ACK      = 4'd0;
    localparam logic [3:0] OPC_ACCESS_ACK_DATA = 4'd1;

    // Corrupt flag position inside the opcode byte
    localparam int CORRUPT_BIT = 7;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_DELIVER   = 2'd3
    } state_e;

    // A packet is a Ch A request (and therefore expects a Ch D reply) when
    // its channel byte is zero.
    function automatic logic is_ch_a(input logic [PKT_W-1:0] p);
        return p[OFF_CHAN*8 +: 8] == {5'd0, CH_A};
    endfunction

    // Response synthesized when the bridge never answers: Ch D,
    // AccessAckData with the corrupt flag, size 0, denied, address/data 0.
    function automatic logic [PKT_W-1:0] timeout_rsp();
        logic [PKT_W-1:0] p;
        p = '0;
        p[OFF_CHAN*8  +: 8] = {5'd0, CH_D};
        p[OFF_OPC*8   +: 8] = {4'd0, OPC_ACCESS_ACK_DATA};
        p[OFF_OPC*8 + CORRUPT_BIT] = 1'b1;
        p[OFF_UNION*8 +: 8] = 8'h01;
        return p;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter. When both requests are present the port that
// did not win last time is chosen; a lone request always wins.
module rr_arbiter_2 (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    // One-hot grant selection
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/tl_host_txn_scheduler.sv
// Shares the UART-to-TileLink bridge between the STL UART client (port 0) and
// the on-FPGA sequencer (port 1). One packet is in flight at a time; a Ch A
// request holds the bridge until its Ch D reply returns (or a watchdog
// synthesizes a denied/corrupt reply) and the reply is handed to the owner.
module tl_host_txn_scheduler
    import tl_pkt_pkg::*;
#(
    parameter int                   TIMEOUT_W      = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'd1000000,
    parameter int                   CNT_W          = 8
) (
    input  logic             sysclk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [PKT_W-1:0] req0_data,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [PKT_W-1:0] req1_data,

    output logic             br_valid,
    input  logic             br_ready,
    output logic [PKT_W-1:0] br_data,

    input  logic             rsp_in_valid,
    output logic             rsp_in_ready,
    input  logic [PKT_W-1:0] rsp_in_data,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [PKT_W-1:0] rsp0_data,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [PKT_W-1:0] rsp1_data,

    output logic             busy,
    output logic [CNT_W-1:0] timeout_count,
    output logic [CNT_W-1:0] stray_count
);

    // Status counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_e                 r_state;
    logic                   r_last_grant;
    logic                   r_owner;
    logic [PKT_W-1:0]       r_pkt_buf;
    logic [PKT_W-1:0]       r_rsp_buf;
    logic [TIMEOUT_W-1:0]   r_timer;
    logic [CNT_W-1:0]       r_timeout_cnt;
    logic [CNT_W-1:0]       r_stray_cnt;

    logic [1:0]             w_grant;
    logic                   w_idle;
    logic                   w_issue;
    logic                   w_wait;
    logic                   w_deliver;
    logic                   w_owner_ready;
    logic                   w_timer_expired;
    logic                   w_timeout_fire;
    logic                   w_stray;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_issue   = (r_state == ST_ISSUE);
    assign w_wait    = (r_state == ST_WAIT_RESP);
    assign w_deliver = (r_state == ST_DELIVER);

    rr_arbiter_2 u_arb (
        .i_req        ({req1_valid, req0_valid}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // A real reply always beats the watchdog in the cycle it expires.
    assign w_timer_expired = (r_timer == '0);
    assign w_timeout_fire  = w_wait && !rsp_in_valid && w_timer_expired;
    assign w_stray         = rsp_in_valid && !w_wait;
    assign w_owner_ready   = r_owner ? rsp1_ready : rsp0_ready;

    // Transaction FSM: arbitrate, issue to bridge, wait for Ch D, deliver
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_pkt_buf    <= '0;
            r_rsp_buf    <= '0;
            r_timer      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        r_pkt_buf    <= w_grant[1] ? req1_data : req0_data;
                        r_owner      <= w_grant[1];
                        r_last_grant <= w_grant[1];
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (br_ready) begin
                        if (is_ch_a(r_pkt_buf)) begin
                            r_timer <= TIMEOUT_CYCLES - 1'b1;
                            r_state <= ST_WAIT_RESP;
                        end else begin
                            // Non-Ch-A traffic gets no reply from the target
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT_RESP: begin
                    r_timer <= r_timer - 1'b1;
                    if (rsp_in_valid) begin
                        r_rsp_buf <= rsp_in_data;
                        r_state   <= ST_DELIVER;
                    end else if (w_timer_expired) begin
                        r_rsp_buf <= timeout_rsp();
                        r_state   <= ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    if (w_owner_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Saturating counts of watchdog expiries and discarded responses
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_timeout_cnt <= '0;
            r_stray_cnt   <= '0;
        end else begin
            if (w_timeout_fire) begin
                r_timeout_cnt <= sat_inc(r_timeout_cnt);
            end
            if (w_stray) begin
                r_stray_cnt <= sat_inc(r_stray_cnt);
            end
        end
    end

    // Only the granted port sees ready, and only while idle
    assign req0_ready = w_idle && w_grant[0];
    assign req1_ready = w_idle && w_grant[1];

    assign br_valid = w_issue;
    assign br_data  = w_issue ? r_pkt_buf : '0;

    // Responses are always consumed; out-of-window ones are just counted
    assign rsp_in_ready = 1'b1;

    assign rsp0_valid = w_deliver && !r_owner;
    assign rsp1_valid = w_deliver &&  r_owner;
    assign rsp0_data  = rsp0_valid ? r_rsp_buf : '0;
    assign rsp1_data  = rsp1_valid ? r_rsp_buf : '0;

    assign busy          = !w_idle;
    assign timeout_count = r_timeout_cnt;
    assign stray_count   = r_stray_cnt;

endmodule

// File: tb/tb_tl_host_txn_scheduler.sv
// Self-checking bench for tl_host_txn_scheduler: directed scenarios followed
// by randomized transactions, checked against a transaction-level model.
module tb_tl_host_txn_scheduler;

    localparam int TO = 16;
    localparam logic [127:0] DENIED = {64'h0, 32'h0, 8'h01, 8'h00, 8'h81, 8'h03};

    logic         sysclk = 1'b0;
    logic         reset  = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [127:0] req0_data = '0, req1_data = '0;
    logic         br_valid;
    logic         br_ready = 1'b0;
    logic [127:0] br_data;
    logic         rsp_in_valid = 1'b0;
    logic         rsp_in_ready;
    logic [127:0] rsp_in_data = '0;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [127:0] rsp0_data, rsp1_data;
    logic         busy;
    logic [7:0]   timeout_count, stray_count;

    tl_host_txn_scheduler #(
        .TIMEOUT_W      (24),
        .TIMEOUT_CYCLES (24'd16),
        .CNT_W          (8)
    ) dut (
        .sysclk        (sysclk),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_data     (req0_data),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_data     (req1_data),
        .br_valid      (br_valid),
        .br_ready      (br_ready),
        .br_data       (br_data),
        .rsp_in_valid  (rsp_in_valid),
        .rsp_in_ready  (rsp_in_ready),
        .rsp_in_data   (rsp_in_data),
        .rsp0_valid    (rsp0_valid),
        .rsp0_ready    (rsp0_ready),
        .rsp0_data     (rsp0_data),
        .rsp1_valid    (rsp1_valid),
        .rsp1_ready    (rsp1_ready),
        .rsp1_data     (rsp1_data),
        .busy          (busy),
        .timeout_count (timeout_count),
        .stray_count   (stray_count)
    );

    always #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction-level model state
    bit           exp_issue    = 1'b0;
    bit           exp_rsp_pend = 1'b0;
    logic [127:0] exp_pkt      = '0;
    logic [127:0] exp_rsp      = '0;
    int           exp_owner    = 0;
    int           exp_to       = 0;
    int           exp_stray    = 0;
    int           model_last   = 1;

    // Observations from the most recent transaction
    logic [127:0] last_rsp  = '0;
    int           last_port = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge sysclk);
        #2;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] mk_pkt(input logic [7:0] chan, input logic [7:0] opc,
                                            input logic [31:0] addr, input logic [63:0] data);
        return {data, addr, 8'h00, 8'h02, opc, chan};
    endfunction

    // Per-cycle comparison of everything the model knows about
    always @(negedge sysclk) begin
        if (!reset) begin
            if (rsp0_valid || rsp1_valid) begin
                check("rsp_expected", 128'(exp_rsp_pend), 128'(1));
                check("rsp_port", 128'({rsp1_valid, rsp0_valid}), 128'((exp_owner == 1) ? 2'b10 : 2'b01));
                check("rsp_data", rsp0_valid ? rsp0_data : rsp1_data, exp_rsp);
                check("rsp_other_data", rsp0_valid ? rsp1_data : rsp0_data, 128'(0));
            end
            if (br_valid) begin
                check("br_expected", 128'(exp_issue), 128'(1));
                check("br_data", br_data, exp_pkt);
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_readies"}, 128'({req1_ready, req0_ready, rsp_in_ready}), 128'(3'b001));
        check({tag, "_valids"}, 128'({br_valid, rsp0_valid, rsp1_valid, busy}), 128'(0));
        check({tag, "_br_data"}, br_data, 128'(0));
        check({tag, "_rsp_data"}, rsp0_data | rsp1_data, 128'(0));
        check({tag, "_counts"}, 128'({timeout_count, stray_count}), 128'(0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; br_ready = 1'b0;
        rsp_in_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        exp_issue = 1'b0; exp_rsp_pend = 1'b0;
        exp_to = 0; exp_stray = 0; model_last = 1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // rsp_k: WAIT cycle (1..TO) carrying the reply, anything else = no reply.
    // abort_k > 0: assert reset in that WAIT cycle instead of finishing.
    task automatic run_txn(input int mask, input logic [127:0] d0, input logic [127:0] d1,
                           input int rsp_k, input logic [127:0] rdata, input int abort_k);
        int w;
        int cnt;
        logic [127:0] pkt;
        bit timed_out;
        w   = (mask == 1) ? 0 : (mask == 2) ? 1 : 1 - model_last;
        pkt = (w == 1) ? d1 : d0;
        req0_valid = ((mask & 1) != 0);
        req1_valid = ((mask & 2) != 0);
        req0_data  = d0;
        req1_data  = d1;
        #1;
        check("grant", 128'({req1_ready, req0_ready}), 128'((w == 1) ? 2'b10 : 2'b01));
        last_port  = req1_ready ? 1 : 0;
        model_last = w;
        exp_owner  = w;
        exp_pkt    = pkt;
        exp_issue  = 1'b1;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("issue_latency", 128'(br_valid), 128'(1));
        cnt = $urandom_range(0, 3);
        repeat (cnt) tick();
        br_ready = 1'b1;
        tick();
        br_ready  = 1'b0;
        exp_issue = 1'b0;
        if (pkt[7:0] != 8'd0) begin
            check("fnf_idle", 128'(busy), 128'(0));
            return;
        end
        timed_out    = !(rsp_k >= 1 && rsp_k <= TO);
        exp_rsp      = timed_out ? DENIED : rdata;
        exp_rsp_pend = 1'b1;
        if (abort_k > 0) begin
            repeat (abort_k - 1) tick();
            do_reset();
            check_reset_state("abort");
            return;
        end
        if (!timed_out) begin
            repeat (rsp_k - 1) tick();
            rsp_in_valid = 1'b1;
            rsp_in_data  = rdata;
            tick();
            rsp_in_valid = 1'b0;
        end else if (exp_to < 255) begin
            exp_to++;
        end
        cnt = 0;
        while (!(rsp0_valid || rsp1_valid) && cnt < 40) begin
            tick();
            cnt++;
        end
        check("deliver_seen", 128'(rsp0_valid | rsp1_valid), 128'(1));
        last_rsp = rsp0_valid ? rsp0_data : rsp1_data;
        cnt = $urandom_range(0, 3);
        repeat (cnt) tick();
        if (w == 1) rsp1_ready = 1'b1;
        else        rsp0_ready = 1'b1;
        tick();
        rsp0_ready   = 1'b0;
        rsp1_ready   = 1'b0;
        exp_rsp_pend = 1'b0;
        check("busy_after_rsp", 128'(busy), 128'(0));
        check("timeout_count", 128'(timeout_count), 128'(exp_to));
    endtask

    task automatic inject_stray(input logic [127:0] d);
        rsp_in_valid = 1'b1;
        rsp_in_data  = d;
        tick();
        rsp_in_valid = 1'b0;
        if (exp_stray < 255) exp_stray++;
        check("stray_count", 128'(stray_count), 128'(exp_stray));
    endtask

    initial begin
        logic [127:0] get0, get1, rsp_a, rsp_b, fnf;
        get0  = mk_pkt(8'h00, 8'h04, 32'h8000_0000, 64'h0);
        get1  = mk_pkt(8'h00, 8'h04, 32'h8000_0010, 64'h0);
        rsp_a = mk_pkt(8'h03, 8'h01, 32'h0, 64'h0000_0000_DEAD_BEEF);
        rsp_b = mk_pkt(8'h03, 8'h01, 32'h0, 64'h0000_0000_1234_5678);
        fnf   = mk_pkt(8'h03, 8'h00, 32'h0, 64'h0);

        do_reset();
        check_reset_state("reset");

        // Simultaneous requests alternate starting with port 0
        for (int i = 0; i < 4; i++) begin
            run_txn(3, get0, get1, 3, rsp_b, 0);
            check("rr_order", 128'(last_port), 128'(i % 2));
        end

        // Single Get from port 0, reply 10 cycles later
        run_txn(1, get0, '0, 10, rsp_a, 0);
        check("get_port", 128'(last_port), 128'(0));
        check("get_rsp_word", 128'(last_rsp[95:64]), 128'(32'hDEADBEEF));

        // No reply: watchdog response
        run_txn(1, get0, '0, 0, '0, 0);
        check("to_byte0", 128'(last_rsp[7:0]), 128'(8'h03));
        check("to_byte1", 128'(last_rsp[15:8]), 128'(8'h81));
        check("to_byte3", 128'(last_rsp[31:24]), 128'(8'h01));
        check("to_count_1", 128'(timeout_count), 128'(1));

        // Reply in the cycle the watchdog expires wins
        run_txn(1, get0, '0, TO, rsp_b, 0);
        check("edge_rsp", last_rsp, rsp_b);
        check("edge_to_count", 128'(timeout_count), 128'(1));

        // Fire-and-forget from port 1, then a stray reply while idle
        run_txn(2, '0, fnf, 0, '0, 0);
        repeat (3) tick();
        check("fnf_busy", 128'(busy), 128'(0));
        inject_stray(rsp_a);
        check("stray_is_1", 128'(stray_count), 128'(1));

        // Reset in the middle of a wait, then normal service resumes
        run_txn(1, get0, '0, 0, '0, 5);
        run_txn(3, get0, get1, 4, rsp_a, 0);
        check("post_reset_port", 128'(last_port), 128'(0));
        check("post_reset_to", 128'(timeout_count), 128'(0));

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            logic [127:0] a, b;
            int m, k;
            a = rnd128();
            b = rnd128();
            if ($urandom_range(0, 3) != 0) a[7:0] = 8'h00;
            else a[7:0] = 8'($urandom_range(1, 255));
            if ($urandom_range(0, 3) != 0) b[7:0] = 8'h00;
            else b[7:0] = 8'($urandom_range(1, 255));
            m = $urandom_range(1, 3);
            k = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO);
            run_txn(m, a, b, k, rnd128(), 0);
            if ($urandom_range(0, 4) == 0) inject_stray(rnd128());
        end

        // Drive the stray counter into saturation
        for (int i = 0; i < 260; i++) inject_stray(rnd128());
        check("stray_saturated", 128'(stray_count), 128'(8'hFF));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
